pipeline_hazard_ctrl: RTL

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 38 +++
 rtl/hazard_sat_counter.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'b00,
    ST_MD_WAIT   = 2'b01,
    ST_IRQ_DRAIN = 2'b10,
    ST_IRQ_ENTER = 2'b11
  } hazard_state_t;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_IRQ    = 2'b10,
    PC_EPC    = 2'b11
  } pc_sel_t;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;

  localparam logic [1:0] DRAIN_CYCLES = 2'd2;

  // One-hot mask for a single stage register
  function automatic logic [3:0] stage_bit(input int idx);
    return 4'b0001 << idx;
  endfunction

  localparam logic [3:0] MASK_NONE  = 4'b0000;
  localparam logic [3:0] MASK_IF    = stage_bit(STG_IF);
  localparam logic [3:0] MASK_MEM   = stage_bit(STG_MEM);
  localparam logic [3:0] MASK_IF_ID = stage_bit(STG_IF) | stage_bit(STG_ID);
  localparam logic [3:0] MASK_ID_EX = stage_bit(STG_ID) | stage_bit(STG_EX);
  localparam logic [3:0] MASK_FRONT = stage_bit(STG_IF) | stage_bit(STG_ID) | stage_bit(STG_EX);
  localparam logic [3:0] MASK_ALL   = 4'b1111;

endpackage

// File: rtl/hazard_sat_counter.sv
// rtl/hazard_sat_counter.sv - saturating event counter used for stall statistics
module hazard_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count qualifying cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush/redirect control; HAZARD_PERF_CNT_EN adds perf_stall_cnt
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_use,
  input  logic       md_start,
  input  logic       md_done,
  input  logic       branch_taken,
  input  logic       eret,
  input  logic       irq_req,
  output logic [3:0] stall,
  output logic [3:0] flush,
  output logic [1:0] pc_sel,
  output logic       irq_ack,
  output logic [1:0] fsm_state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  hazard_state_t state, state_nxt;
  logic [1:0]    drain_cnt, drain_cnt_nxt;
  pc_sel_t       pc_sel_e;

  // State and drain counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_RUN;
      drain_cnt <= 2'd0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Next state plus Mealy stall/flush/redirect; reset forces a full flush
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    stall         = MASK_NONE;
    flush         = MASK_NONE;
    pc_sel_e      = PC_SEQ;
    if (rst) begin
      state_nxt     = ST_RUN;
      drain_cnt_nxt = 2'd0;
      flush         = MASK_ALL;
    end else begin
      case (state)
        ST_RUN: begin
          if (irq_req) begin
            stall         = MASK_IF;
            flush         = MASK_ID_EX;
            state_nxt     = ST_IRQ_DRAIN;
            drain_cnt_nxt = DRAIN_CYCLES;
          end else if (md_start) begin
            state_nxt = ST_MD_WAIT;
          end else if (load_use) begin
            // Redirects seen alongside load_use wait for re-presentation
            stall = MASK_FRONT;
            flush = MASK_MEM;
          end else if (eret) begin
            pc_sel_e = PC_EPC;
            flush    = MASK_IF_ID;
          end else if (branch_taken) begin
            pc_sel_e = PC_BRANCH;
            flush    = MASK_IF_ID;
          end
        end
        ST_MD_WAIT: begin
          if (md_done) begin
            state_nxt = ST_RUN;
          end else begin
            stall = MASK_FRONT;
            flush = MASK_MEM;
          end
        end
        ST_IRQ_DRAIN: begin
          stall = MASK_IF;
          flush = MASK_ID_EX;
          if (drain_cnt <= 2'd1) begin
            drain_cnt_nxt = 2'd0;
            state_nxt     = ST_IRQ_ENTER;
          end else begin
            drain_cnt_nxt = drain_cnt - 2'd1;
          end
        end
        ST_IRQ_ENTER: begin
          pc_sel_e  = PC_IRQ;
          flush     = MASK_FRONT;
          state_nxt = ST_RUN;
        end
        default: begin
          state_nxt = ST_RUN;
        end
      endcase
    end
  end

  assign pc_sel    = pc_sel_e;
  assign irq_ack   = (state == ST_IRQ_ENTER);
  assign fsm_state = state;

`ifdef HAZARD_PERF_CNT_EN
  hazard_sat_counter #(
    .WIDTH(32)
  ) u_perf_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (|stall),
    .count(perf_stall_cnt)
  );
`endif

endmodule
